// File: rtl/lcd_cmd_host_if.sv
// Upstream command-push bus and LCD_CTRL issue/handshake signals for lcd_cmd_host.
// The slave modport is the host itself; master is the environment around it.
interface lcd_cmd_host_if #(
    parameter int AW = 4
);
    logic          push;
    logic [3:0]    push_cmd;
    logic          full;
    logic          empty;
    logic [AW:0]   level;
    logic          overflow;
    logic [3:0]    cmd;
    logic          cmd_valid;
    logic          busy;
    logic          done;
    logic          frame_done;
    logic [7:0]    frame_cnt;

    modport slave (
        input  push, push_cmd, busy, done,
        output full, empty, level, overflow, cmd, cmd_valid, frame_done, frame_cnt
    );

    modport master (
        output push, push_cmd, busy, done,
        input  full, empty, level, overflow, cmd, cmd_valid, frame_done, frame_cnt
    );
endinterface

// File: rtl/lcd_cmd_host.sv
// Command FIFO plus issue FSM driving LCD_CTRL's cmd/cmd_valid/busy/done handshake,
// with frame-completion pulse and counter reported upstream.
module lcd_cmd_host #(
    parameter int         DEPTH     = 16,
    parameter int         AW        = 4,
    parameter logic [3:0] WRITE_CMD = 4'h0
) (
    input  logic            clk,
    input  logic            reset,
    lcd_cmd_host_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GUARD,
        WAIT_DONE
    } state_t;

    state_t        r_state;
    state_t        w_nextState;

    logic [3:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [AW:0]   r_count;
    logic          r_overflow;

    logic [3:0]    r_cmd;
    logic          r_cmdValid;
    logic          r_frameDone;
    logic [7:0]    r_frameCnt;

    logic          w_full;
    logic          w_empty;
    logic          w_pushAccept;
    logic          w_pop;
    logic          w_frameDone;

    // Full is judged before any same-cycle pop, so a push into a full FIFO is always dropped.
    assign w_full       = (r_count == (AW+1)'(DEPTH));
    assign w_empty      = (r_count == '0);
    assign w_pushAccept = bus.push && !w_full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // GUARD is a dead cycle so LCD_CTRL's late-rising busy is never mistaken for idle.
    always_comb begin
        w_nextState = r_state;
        w_pop       = 1'b0;
        w_frameDone = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty && !bus.busy) begin
                    w_pop       = 1'b1;
                    w_nextState = ISSUE;
                end
            end
            ISSUE: begin
                w_nextState = GUARD;
            end
            GUARD: begin
                w_nextState = (r_cmd == WRITE_CMD) ? WAIT_DONE : IDLE;
            end
            WAIT_DONE: begin
                if (bus.done) begin
                    w_frameDone = 1'b1;
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_pushAccept) begin
            r_mem[r_wrPtr] <= bus.push_cmd;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_pushAccept) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            case ({w_pushAccept, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (bus.push && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // cmd is only reloaded on the issuing edge, so it holds the last issued command.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cmd       <= 4'h0;
            r_cmdValid  <= 1'b0;
            r_frameDone <= 1'b0;
            r_frameCnt  <= 8'd0;
        end else begin
            r_cmdValid  <= w_pop;
            r_frameDone <= w_frameDone;
            if (w_pop) begin
                r_cmd <= r_mem[r_rdPtr];
            end
            if (w_frameDone) begin
                r_frameCnt <= r_frameCnt + 8'd1;
            end
        end
    end

    assign bus.full       = w_full;
    assign bus.empty      = w_empty;
    assign bus.level      = r_count;
    assign bus.overflow   = r_overflow;
    assign bus.cmd        = r_cmd;
    assign bus.cmd_valid  = r_cmdValid;
    assign bus.frame_done = r_frameDone;
    assign bus.frame_cnt  = r_frameCnt;

endmodule

// File: tb/tb_lcd_cmd_host.sv
// Directed self-checking bench for lcd_cmd_host: reset, issue order/spacing,
// busy hold-off, write/done handshake, overflow and mid-operation reset.
module tb_lcd_cmd_host;

    logic clk;
    logic reset;
    int   checks;
    int   passed;
    int   fails;
    int   cycle;
    int   base;

    logic [3:0] issued [$];
    int         issueCycle [$];

    lcd_cmd_host_if #(.AW(4)) bus ();

    lcd_cmd_host #(
        .DEPTH(16),
        .AW(4),
        .WRITE_CMD(4'h0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle = cycle + 1;

    // Record every issue strobe with the command it carries and when it happened.
    always @(posedge clk) begin
        #1;
        if (bus.cmd_valid === 1'b1) begin
            issued.push_back(bus.cmd);
            issueCycle.push_back(cycle);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic applyStimulus(input logic p, input logic [3:0] c, input logic b, input logic d);
        bus.push     = p;
        bus.push_cmd = c;
        bus.busy     = b;
        bus.done     = d;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) passed++;
        else begin
            fails++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
            $error("[TB] check %s mismatched", tag);
        end
    endtask

    initial begin
        checks = 0;
        passed = 0;
        fails  = 0;
        cycle  = 0;
        reset  = 1'b0;
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);

        waitCycles(3);
        checkOutput("rst_cmd",        32'(bus.cmd),        32'h0);
        checkOutput("rst_cmd_valid",  32'(bus.cmd_valid),  32'h0);
        checkOutput("rst_full",       32'(bus.full),       32'h0);
        checkOutput("rst_empty",      32'(bus.empty),      32'h1);
        checkOutput("rst_level",      32'(bus.level),      32'h0);
        checkOutput("rst_overflow",   32'(bus.overflow),   32'h0);
        checkOutput("rst_frame_done", 32'(bus.frame_done), 32'h0);
        checkOutput("rst_frame_cnt",  32'(bus.frame_cnt),  32'h0);
        reset = 1'b1;
        waitCycles(10);
        checkOutput("idle_no_issue",  32'(issued.size()),  32'd0);

        // Basic issue: 1,2,3 back-to-back.
        applyStimulus(1'b1, 4'h1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 4'h2, 1'b0, 1'b0);
        checkOutput("push_level1",    32'(bus.level),      32'd1);
        checkOutput("push_no_valid",  32'(bus.cmd_valid),  32'h0);
        tick();
        checkOutput("issue1_valid",   32'(bus.cmd_valid),  32'h1);
        checkOutput("issue1_cmd",     32'(bus.cmd),        32'h1);
        checkOutput("pushpop_level",  32'(bus.level),      32'd1);
        applyStimulus(1'b1, 4'h3, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
        checkOutput("issue1_strobe",  32'(bus.cmd_valid),  32'h0);
        checkOutput("level2",         32'(bus.level),      32'd2);
        waitCycles(12);
        checkOutput("basic_count",    32'(issued.size()),  32'd3);
        checkOutput("basic_cmd0",     32'(issued[0]),      32'h1);
        checkOutput("basic_cmd1",     32'(issued[1]),      32'h2);
        checkOutput("basic_cmd2",     32'(issued[2]),      32'h3);
        checkOutput("basic_space01",  32'(issueCycle[1] - issueCycle[0]), 32'd3);
        checkOutput("basic_space12",  32'(issueCycle[2] - issueCycle[1]), 32'd3);
        checkOutput("basic_empty",    32'(bus.empty),      32'h1);

        // Busy hold-off.
        applyStimulus(1'b1, 4'h4, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
        waitCycles(19);
        checkOutput("busy_held",      32'(issued.size()),  32'd3);
        checkOutput("busy_level",     32'(bus.level),      32'd1);
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
        tick();
        checkOutput("busy_rel_valid", 32'(bus.cmd_valid),  32'h1);
        checkOutput("busy_rel_cmd",   32'(bus.cmd),        32'h4);
        waitCycles(4);

        // Write command followed by 5: 5 must wait for done.
        applyStimulus(1'b1, 4'h0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 4'h5, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
        waitCycles(10);
        checkOutput("wr_count",       32'(issued.size()),  32'd5);
        checkOutput("wr_cmd",         32'(bus.cmd),        32'h0);
        checkOutput("wr_level",       32'(bus.level),      32'd1);
        checkOutput("wr_no_fd",       32'(bus.frame_done), 32'h0);
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
        checkOutput("fd_pulse",       32'(bus.frame_done), 32'h1);
        checkOutput("fd_cnt1",        32'(bus.frame_cnt),  32'd1);
        checkOutput("fd_no_valid",    32'(bus.cmd_valid),  32'h0);
        tick();
        checkOutput("fd_one_cycle",   32'(bus.frame_done), 32'h0);
        checkOutput("after_wr_valid", 32'(bus.cmd_valid),  32'h1);
        checkOutput("after_wr_cmd",   32'(bus.cmd),        32'h5);
        waitCycles(5);
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
        checkOutput("stray_no_fd",    32'(bus.frame_done), 32'h0);
        checkOutput("stray_cnt",      32'(bus.frame_cnt),  32'd1);
        tick();

        // Overflow: 18 pushes while busy; values 1..15,1,2,3.
        for (int i = 0; i < 18; i++) begin
            applyStimulus(1'b1, 4'((i % 15) + 1), 1'b1, 1'b0);
            tick();
            if (i == 15) begin
                checkOutput("ovf_full16",    32'(bus.full),     32'h1);
                checkOutput("ovf_level16",   32'(bus.level),    32'd16);
                checkOutput("ovf_not_yet",   32'(bus.overflow), 32'h0);
            end
        end
        applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
        checkOutput("ovf_full",       32'(bus.full),       32'h1);
        checkOutput("ovf_level",      32'(bus.level),      32'd16);
        checkOutput("ovf_flag",       32'(bus.overflow),   32'h1);
        base = issued.size();
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
        waitCycles(60);
        checkOutput("ovf_issued",     32'(issued.size() - base), 32'd16);
        for (int k = 0; k < 16; k++) begin
            checkOutput($sformatf("ovf_order%0d", k), 32'(issued[base + k]), 32'((k % 15) + 1));
        end
        checkOutput("ovf_drain_empty", 32'(bus.empty),     32'h1);
        checkOutput("ovf_sticky",     32'(bus.overflow),   32'h1);

        // Reset while waiting for done with five entries queued.
        applyStimulus(1'b1, 4'h0, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 4'(5 + k), 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
        waitCycles(6);
        checkOutput("mid_level5",     32'(bus.level),      32'd5);
        checkOutput("mid_cmd_wr",     32'(bus.cmd),        32'h0);
        base = issued.size();
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_empty",  32'(bus.empty),      32'h1);
        checkOutput("mid_rst_level",  32'(bus.level),      32'd0);
        checkOutput("mid_rst_valid",  32'(bus.cmd_valid),  32'h0);
        checkOutput("mid_rst_cnt",    32'(bus.frame_cnt),  32'd0);
        checkOutput("mid_rst_ovf",    32'(bus.overflow),   32'h0);
        tick();
        reset = 1'b1;
        waitCycles(15);
        checkOutput("post_rst_none",  32'(issued.size() - base), 32'd0);
        checkOutput("post_rst_empty", 32'(bus.empty),      32'h1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
